poco_alu: RTL and testbench



---
 rtl/poco_alu_if.sv | 22 ++
 rtl/poco_alu.sv | 102 ++++++++++
 tb/tb_poco_alu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/poco_alu_if.sv
// poco_alu_if: operand/command/result bundle between the register-file read
// side (master) and the POCO ALU (slave). clk/rst stay outside the bundle.
interface poco_alu_if;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  com;
  logic        fe;
  logic [15:0] y;
  logic        zf;
  logic        cf;
  logic        nf;

  modport master (
    output a, b, com, fe,
    input  y, zf, cf, nf
  );

  modport slave (
    input  a, b, com, fe,
    output y, zf, cf, nf
  );
endinterface

// File: rtl/poco_alu.sv
// poco_alu: 16-bit combinational ALU with a registered zero/carry/negative
// flag bank. y is a pure function of a, b, com.
// Optional build macro POCO_ALU_FLAGS_EN: when defined, the flag registers
// and fe load path are built; when undefined, zf/cf/nf are tied to 0 and
// clk/rst/fe are unused.
module poco_alu (
  input  logic       clk,
  input  logic       rst,
  poco_alu_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_PASSA = 3'b000,
    OP_PASSB = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_SHL   = 3'b100,
    OP_SHR   = 3'b101,
    OP_ADD   = 3'b110,
    OP_SUB   = 3'b111
  } op_e;

  op_e         op;
  logic [16:0] sum;
  logic [16:0] dif;
  logic [15:0] y_c;
  logic        c_next;
  logic        z_next;
  logic        n_next;

  assign op = op_e'(bus.com);

  // Zero-extended add/sub so bit 16 is carry-out (add) or borrow (sub).
  assign sum = {1'b0, bus.a} + {1'b0, bus.b};
  assign dif = {1'b0, bus.a} - {1'b0, bus.b};

  // Result and carry candidate, selected by the command.
  always_comb begin
    y_c    = 16'h0000;
    c_next = 1'b0;
    unique case (op)
      OP_PASSA: y_c = bus.a;
      OP_PASSB: y_c = bus.b;
      OP_AND:   y_c = bus.a & bus.b;
      OP_OR:    y_c = bus.a | bus.b;
      OP_SHL: begin
        y_c    = {bus.a[14:0], 1'b0};
        c_next = bus.a[15];
      end
      OP_SHR: begin
        y_c    = {1'b0, bus.a[15:1]};
        c_next = bus.a[0];
      end
      OP_ADD: begin
        y_c    = sum[15:0];
        c_next = sum[16];
      end
      OP_SUB: begin
        y_c    = dif[15:0];
        c_next = dif[16];
      end
      default: begin
        y_c    = 16'h0000;
        c_next = 1'b0;
      end
    endcase
  end

  assign z_next = (y_c == 16'h0000);
  assign n_next = y_c[15];
  assign bus.y  = y_c;

`ifdef POCO_ALU_FLAGS_EN
  logic zf_q, cf_q, nf_q;

  // Flag bank: reset clears, fe loads the current op's flags, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      cf_q <= 1'b0;
      nf_q <= 1'b0;
    end else if (bus.fe) begin
      zf_q <= z_next;
      cf_q <= c_next;
      nf_q <= n_next;
    end
  end

  assign bus.zf = zf_q;
  assign bus.cf = cf_q;
  assign bus.nf = nf_q;
`else
  // Flags compiled out: outputs constant, clock/reset/enable intentionally unused.
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{clk, rst, bus.fe, z_next, c_next, n_next};

  assign bus.zf = 1'b0;
  assign bus.cf = 1'b0;
  assign bus.nf = 1'b0;
`endif

endmodule

// File: tb/tb_poco_alu.sv
// tb_poco_alu: directed vectors for poco_alu; flag expectations follow the
// POCO_ALU_FLAGS_EN build (all zero when the flag bank is compiled out).
module tb_poco_alu;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

`ifdef POCO_ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  poco_alu_if bus ();

  poco_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkf(input string tag, input logic z, input logic c, input logic n);
    logic [2:0] exp;
    logic [2:0] obs;
    exp = FLAGS ? {z, c, n} : 3'b000;
    obs = {bus.zf, bus.cf, bus.nf};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: zcn got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive a vector while clk is low, then let it settle.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] com,
                       input logic fe, input logic r);
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.com = com;
    bus.fe  = fe;
    rst     = r;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Reset state
    drive(16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    edge_settle();
    chkf("reset", 1'b0, 1'b0, 1'b0);
    chk16("reset_y", bus.y, 16'h0000);

    // Pass / logic / shifts / arithmetic, fe=0
    drive(16'hFFFF, 16'h0000, 3'b000, 1'b0, 1'b0); chk16("pass_a", bus.y, 16'hFFFF);
    drive(16'h0000, 16'hFFFF, 3'b001, 1'b0, 1'b0); chk16("pass_b", bus.y, 16'hFFFF);
    drive(16'hFF00, 16'hAAAA, 3'b010, 1'b0, 1'b0); chk16("and",    bus.y, 16'hAA00);
    drive(16'hFF00, 16'hF0F0, 3'b011, 1'b0, 1'b0); chk16("or",     bus.y, 16'hFFF0);
    drive(16'h0008, 16'h0000, 3'b100, 1'b0, 1'b0); chk16("shl",    bus.y, 16'h0010);
    drive(16'h0008, 16'h0000, 3'b101, 1'b0, 1'b0); chk16("shr",    bus.y, 16'h0004);
    drive(16'hFFFE, 16'h0001, 3'b110, 1'b0, 1'b0); chk16("add",    bus.y, 16'hFFFF);
    drive(16'hFFF1, 16'h0001, 3'b111, 1'b0, 1'b0); chk16("sub",    bus.y, 16'hFFF0);
    edge_settle();
    chkf("fe0_after_reset", 1'b0, 1'b0, 1'b0);

    // Shift-out carry
    drive(16'h8001, 16'h0000, 3'b100, 1'b1, 1'b0); chk16("shl_out_y", bus.y, 16'h0002);
    edge_settle();
    chkf("shl_out_flags", 1'b0, 1'b1, 1'b0);

    // Shift-right out with zero result
    drive(16'h0001, 16'h0000, 3'b101, 1'b1, 1'b0); chk16("shr_out_y", bus.y, 16'h0000);
    edge_settle();
    chkf("shr_out_flags", 1'b1, 1'b1, 1'b0);

    // Add wrap to zero with carry
    drive(16'hFFFF, 16'h0001, 3'b110, 1'b1, 1'b0); chk16("add_wrap_y", bus.y, 16'h0000);
    edge_settle();
    chkf("add_wrap_flags", 1'b1, 1'b1, 1'b0);

    // Add, negative result, no carry
    drive(16'h8000, 16'h0000, 3'b110, 1'b1, 1'b0); chk16("add_neg_y", bus.y, 16'h8000);
    edge_settle();
    chkf("add_neg_flags", 1'b0, 1'b0, 1'b1);

    // Sub without borrow
    drive(16'h0005, 16'h0003, 3'b111, 1'b1, 1'b0); chk16("sub_nb_y", bus.y, 16'h0002);
    edge_settle();
    chkf("sub_nb_flags", 1'b0, 1'b0, 1'b0);

    // Sub with borrow
    drive(16'h0000, 16'h0001, 3'b111, 1'b1, 1'b0); chk16("sub_b_y", bus.y, 16'hFFFF);
    edge_settle();
    chkf("sub_b_flags", 1'b0, 1'b1, 1'b1);

    // Hold with fe=0 and new operands
    drive(16'h1234, 16'h0001, 3'b110, 1'b0, 1'b0); chk16("hold_y", bus.y, 16'h1235);
    edge_settle();
    chkf("hold_flags", 1'b0, 1'b1, 1'b1);
    edge_settle();
    chkf("hold_flags2", 1'b0, 1'b1, 1'b1);

    // Reset beats fe; y keeps tracking
    drive(16'h0000, 16'h0001, 3'b111, 1'b1, 1'b1); chk16("rst_y", bus.y, 16'hFFFF);
    edge_settle();
    chkf("rst_flags", 1'b0, 1'b0, 1'b0);
    drive(16'h0005, 16'h0000, 3'b000, 1'b1, 1'b1); chk16("rst_track_y", bus.y, 16'h0005);
    edge_settle();
    chkf("rst_flags2", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
